// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor calculation
// and a parity helper used by both directions of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk, input int baud, input int os);
    return (clk + (baud * os) / 2) / (baud * os);
  endfunction

  // XOR of all bits; callers zero-extend narrower words.
  function automatic logic xor_reduce(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle TICKo every DIV clocks, restartable
// at phase 0 through a synchronous clear.
module uart_baud_gen #(
  parameter int DIV = 2
) (
  input  logic CLKip,
  input  logic RSTi,
  input  logic CLRi,
  output logic TICKo
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (CLRi || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICKo = (cnt_q == LAST) && !CLRi;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver feeding the RX FIFO write port: majority-voted
// bits, optional parity, mid-stop frame resolution with error/overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  CLKip,
  input  logic                  RSTi,
  input  logic                  RXi,
  input  logic                  FULLi,
  output logic [DATA_WIDTH-1:0] DATAo,
  output logic                  VALIDo,
  output logic                  BUSYo,
  output logic                  FRAME_ERRo,
  output logic                  PARITY_ERRo,
  output logic                  OVERRUNo
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH + 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx: DIV=%0d is below 2; clock too slow for BAUD*OVERSAMPLE", DIV);
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
    $error("uart_rx: OVERSAMPLE=%0d must be even and at least 8", OVERSAMPLE);
  end
  if ((DATA_WIDTH < 1) || (DATA_WIDTH > 64)) begin : g_dw_check
    $error("uart_rx: DATA_WIDTH=%0d out of range 1..64", DATA_WIDTH);
  end

  uart_rx_state_t        state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [SW-1:0]         s_cnt_q, s_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            vote_q, vote_d;
  logic                  par_err_q, par_err_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic                  ovr_q, ovr_d;

  logic rx_s;
  logic tick;
  logic decide;
  logic bit_end;
  logic majority;

  assign rx_s = sync_q[1];

  // Ticks run only while a frame is in progress, so every frame starts at phase 0.
  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .CLKip(CLKip),
    .RSTi (RSTi),
    .CLRi (state_q == IDLE),
    .TICKo(tick)
  );

  // Votes land on the ticks taking s_cnt to M-1 and M; the third is live on the M+1 tick.
  assign decide   = tick && (s_cnt_q == SW'(M));
  assign bit_end  = tick && (s_cnt_q == SW'(OVERSAMPLE - 1));
  assign majority = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  always_comb begin
    sync_d    = {sync_q[0], RXi};
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    vote_d    = vote_q;
    par_err_d = par_err_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (tick) begin
      s_cnt_d = bit_end ? '0 : s_cnt_q + SW'(1);
      if (s_cnt_q == SW'(M - 2)) vote_d[0] = rx_s;
      if (s_cnt_q == SW'(M - 1)) vote_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        s_cnt_d   = '0;
        bit_cnt_d = '0;
        par_err_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (decide && majority) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) shift_d = DATA_WIDTH'({majority, shift_q} >> 1);
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (decide) begin
          par_err_d = (xor_reduce(64'(shift_q)) ^ majority) != 1'(PARITY_ODD);
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Resolve at mid-stop so a back-to-back start edge is never missed.
        if (decide) begin
          state_d = IDLE;
          perr_d  = par_err_q;
          if (!majority) begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end else if (!par_err_q) begin
            if (FULLi) begin
              ovr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKip or posedge RSTi) begin
    if (RSTi) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      vote_q    <= '0;
      par_err_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      vote_q    <= vote_d;
      par_err_q <= par_err_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign DATAo       = data_q;
  assign VALIDo      = valid_q;
  assign BUSYo       = (state_q != IDLE);
  assign FRAME_ERRo  = ferr_q;
  assign PARITY_ERRo = perr_q;
  assign OVERRUNo    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 and an 8E1 receiver driven by
// directed frames, checked against a frame-level outcome model.
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DIV = 2;
  localparam int M   = OS / 2;

  logic       CLKip = 1'b0;
  logic       RSTi  = 1'b1;
  logic       rx0   = 1'b1;
  logic       rx1   = 1'b1;
  logic       full0 = 1'b0;
  logic       full1 = 1'b0;
  logic [7:0] data0, data1;
  logic       val0, busy0, ferr0, perr0, ovr0;
  logic       val1, busy1, ferr1, perr1, ovr1;

  always #5 CLKip = ~CLKip;

  uart_rx #(
    .CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(OS),
    .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut (
    .CLKip(CLKip), .RSTi(RSTi), .RXi(rx0), .FULLi(full0),
    .DATAo(data0), .VALIDo(val0), .BUSYo(busy0),
    .FRAME_ERRo(ferr0), .PARITY_ERRo(perr0), .OVERRUNo(ovr0)
  );

  uart_rx #(
    .CLK_FREQ(3_200_000), .BAUD(100_000), .OVERSAMPLE(OS),
    .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut_p (
    .CLKip(CLKip), .RSTi(RSTi), .RXi(rx1), .FULLi(full1),
    .DATAo(data1), .VALIDo(val1), .BUSYo(busy1),
    .FRAME_ERRo(ferr1), .PARITY_ERRo(perr1), .OVERRUNo(ovr1)
  );

  // Expected frame outcome; kind bits are {overrun, parity_err, frame_err, valid}.
  typedef struct {
    int         inst;
    logic [3:0] kind;
    logic [7:0] data;
    longint     exp_cyc;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_data[2];
  longint     last_valid_cyc[2];
  longint     cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(posedge CLKip) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame outcome straight from the receiver rules (both instances use even parity).
  function automatic logic [3:0] expect_kind(input logic [7:0] d, input bit pen,
                                             input logic pbit, input logic stopb, input logic full);
    logic par_bad;
    par_bad = pen && ((^d ^ pbit) != 1'b0);
    if (stopb && !par_bad) return full ? 4'b1000 : 4'b0001;
    return {1'b0, par_bad, !stopb, 1'b0};
  endfunction

  task automatic compare_inst(input int i, input logic [3:0] pl, input logic [7:0] dq);
    int k;
    k = -1;
    for (int j = 0; j < evq.size(); j++) begin
      if (evq[j].inst == i) begin
        k = j;
        break;
      end
    end
    if (pl != 4'b0000) begin
      if (k < 0) begin
        check($sformatf("unexpected_pulse_dut%0d", i), pl, 4'b0000);
      end else begin
        check($sformatf("pulse_kind_dut%0d", i), pl, evq[k].kind);
        check_range($sformatf("pulse_time_dut%0d", i), cyc,
                    evq[k].exp_cyc - DIV, evq[k].exp_cyc + DIV);
        if (evq[k].kind[0]) begin
          check($sformatf("valid_data_dut%0d", i), dq, evq[k].data);
          model_data[i] = evq[k].data;
        end
        if (pl[0]) last_valid_cyc[i] = cyc;
        $display("dut%0d frame 0x%02h outcome %b at cycle %0d", i, evq[k].data, pl, cyc);
        evq.delete(k);
      end
    end else if (k >= 0 && cyc > evq[k].exp_cyc + DIV) begin
      check($sformatf("event_by_deadline_dut%0d", i), pl, evq[k].kind);
      if (evq[k].kind[0]) model_data[i] = evq[k].data;
      evq.delete(k);
    end
    check($sformatf("data_hold_dut%0d", i), dq, model_data[i]);
  endtask

  always @(negedge CLKip) begin
    compare_inst(0, {ovr0, perr0, ferr0, val0}, data0);
    compare_inst(1, {ovr1, perr1, ferr1, val1}, data1);
  end

  task automatic wait_until(input longint t);
    while (cyc < t) begin
      @(posedge CLKip);
      #1;
    end
  endtask

  task automatic idle(input int n);
    wait_until(cyc + n);
  endtask

  task automatic drive_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  // per100 = bit period in hundredths of a clock; abort_bit >= 0 stops mid-bit, no outcome expected.
  task automatic send_frame(input int sel, input logic [7:0] data, input bit pen, input logic pbit,
                            input logic stopb, input int per100, input int abort_bit);
    logic [10:0] bits;
    int          n;
    longint      base;
    ev_t         ev;
    n = pen ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) bits[1+b] = data[b];
    if (pen) bits[9] = pbit;
    bits[n-1] = stopb;
    base = cyc;
    if (abort_bit < 0) begin
      ev.inst    = sel;
      ev.kind    = expect_kind(data, pen, pbit, stopb, (sel == 0) ? full0 : full1);
      ev.data    = data;
      // Two synchroniser clocks, then (bits before stop)*OS + M + 1 ticks of DIV, plus the output register.
      ev.exp_cyc = base + 2 + longint'(((n - 1) * OS + M + 1) * DIV + 1);
      evq.push_back(ev);
    end
    for (int i = 0; i < n; i++) begin
      wait_until(base + longint'(i * per100 / 100));
      drive_rx(sel, bits[i]);
      if (i == abort_bit) begin
        wait_until(base + longint'((2 * i + 1) * per100 / 200));
        return;
      end
    end
    wait_until(base + longint'(n * per100 / 100));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    bit     all_busy;
    model_data[0] = 8'h00;
    model_data[1] = 8'h00;
    last_valid_cyc[0] = 0;
    last_valid_cyc[1] = 0;

    repeat (3) @(posedge CLKip);
    #1;
    check("reset_outputs_dut0", {data0, val0, busy0, ferr0, perr0, ovr0}, 0);
    check("reset_outputs_dut1", {data1, val1, busy1, ferr1, perr1, ovr1}, 0);
    RSTi = 1'b0;
    idle(10);

    // 1: nominal 8N1 frame, latency pinned by hand: 2 + 153*2 + 1 = 309 clocks from RXi.
    t0 = cyc;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 3200, -1);
    check_range("a5_latency", last_valid_cyc[0] - t0, 307, 311);
    check("data_after_a5", data0, 8'hA5);
    idle(20);

    // 2: 6-clock glitch rejected in START; BUSY clears within 20 clocks of rx_s falling.
    t0 = cyc;
    rx0 = 1'b0;
    wait_until(t0 + 6);
    check("glitch_busy_high", busy0, 1'b1);
    rx0 = 1'b1;
    wait_until(t0 + 22);
    check("glitch_busy_cleared", busy0, 1'b0);
    idle(30);

    // 3: framing error, line held low, then recovery.
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 3200, -1);
    all_busy = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (!busy0) all_busy = 1'b0;
      idle(1);
    end
    check("busy_during_break", all_busy, 1'b1);
    rx0 = 1'b1;
    idle(5);
    check("idle_after_break", busy0, 1'b0);
    idle(10);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 3200, -1);
    idle(20);

    // 4: overrun drops the frame and keeps DATAo.
    full0 = 1'b1;
    send_frame(0, 8'h7E, 0, 1'b0, 1'b1, 3200, -1);
    full0 = 1'b0;
    check("data_kept_after_overrun", data0, 8'h5A);
    idle(20);
    send_frame(0, 8'h12, 0, 1'b0, 1'b1, 3200, -1);
    check("data_after_overrun_recovery", data0, 8'h12);
    idle(20);

    // 6a: back-to-back frames at a 2% fast line.
    send_frame(0, 8'h00, 0, 1'b0, 1'b1, 3136, -1);
    send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 3136, -1);
    send_frame(0, 8'h55, 0, 1'b0, 1'b1, 3136, -1);
    check("data_after_b2b", data0, 8'h55);
    idle(20);

    // 5: even parity on the second receiver.
    send_frame(1, 8'h01, 1, 1'b1, 1'b1, 3200, -1);
    check("data_parity_ok", data1, 8'h01);
    idle(20);
    send_frame(1, 8'h01, 1, 1'b0, 1'b1, 3200, -1);
    idle(20);
    send_frame(1, 8'h81, 1, 1'b1, 1'b0, 3200, -1);
    idle(40);
    rx1 = 1'b1;
    idle(10);
    send_frame(1, 8'hF0, 1, 1'b0, 1'b1, 3200, -1);
    check("data_parity_f0", data1, 8'hF0);
    idle(20);

    // 6b: reset during data bit 3 abandons the frame silently.
    send_frame(0, 8'h96, 0, 1'b0, 1'b1, 3200, 4);
    RSTi = 1'b1;
    evq.delete();
    model_data[0] = 8'h00;
    model_data[1] = 8'h00;
    #1;
    check("midframe_reset_dut0", {data0, val0, busy0, ferr0, perr0, ovr0}, 0);
    check("midframe_reset_dut1", {data1, val1, busy1, ferr1, perr1, ovr1}, 0);
    rx0 = 1'b1;
    idle(3);
    RSTi = 1'b0;
    idle(20);
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1, 3200, -1);
    check("data_after_reset_frame", data0, 8'hC3);
    idle(20);

    check("model_queue_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
